// File: rtl/ram_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter_pkg
//   Shared memory-subsystem definitions: owner-state encoding of the RAM
//   access arbiter, requester index constants and the round-robin helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ram_access_arbiter_pkg;

  // Owner state machine encoding. 2'd3 is unused and decodes as OWN_NONE.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  // Requester indices, also used as the last_grant / return-tag values.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Under contention the requester that was not granted most recently wins.
  function automatic logic rr_winner(input logic last_grant);
    return (last_grant == REQ_B) ? REQ_A : REQ_B;
  endfunction

endpackage

// File: rtl/ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// ram_access_arbiter
//   Two-requester arbiter in front of a single-port RAM with 1-cycle read
//   latency. At most one access is issued per cycle; a requester can lock
//   ownership across several accesses (e.g. read-modify-write). Read data is
//   returned to the requester that issued the read, one cycle after its ack.
//
// Ports
//   clk, sync_reset            clock, synchronous active-high reset
//   a_*/b_* (inputs)           req, lock, addr, din, write_en (0 = read)
//   a_*/b_* (outputs)          ack (issued this cycle), rd_valid, dout
//   ram_addr/ram_din/ram_write_en   request to the RAM (combinational)
//   ram_dout                   RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      sync_reset,

  input  logic                      a_req,
  input  logic                      a_lock,
  input  logic [ADDR_WIDTH-1:0]     a_addr,
  input  logic [DATA_WIDTH-1:0]     a_din,
  input  logic [DATA_WIDTH/8-1:0]   a_write_en,
  output logic                      a_ack,
  output logic                      a_rd_valid,
  output logic [DATA_WIDTH-1:0]     a_dout,

  input  logic                      b_req,
  input  logic                      b_lock,
  input  logic [ADDR_WIDTH-1:0]     b_addr,
  input  logic [DATA_WIDTH-1:0]     b_din,
  input  logic [DATA_WIDTH/8-1:0]   b_write_en,
  output logic                      b_ack,
  output logic                      b_rd_valid,
  output logic [DATA_WIDTH-1:0]     b_dout,

  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_din,
  output logic [DATA_WIDTH/8-1:0]   ram_write_en,
  input  logic [DATA_WIDTH-1:0]     ram_dout
);

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic                    last_grant;
  logic                    tag_valid;   // a read was issued last cycle
  logic                    tag_who;     // which requester that read belongs to
  logic [DATA_WIDTH-1:0]   a_hold;
  logic [DATA_WIDTH-1:0]   b_hold;

  logic                    grant_valid;
  logic                    grant_who;
  logic [DATA_WIDTH/8-1:0] grant_we;
  logic                    grant_is_read;

  // Grant selection. Reset blocks every grant so nothing reaches the RAM.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_who   = REQ_A;
    if (!sync_reset) begin
      case (state)
        OWN_A: begin
          grant_valid = a_req;
          grant_who   = REQ_A;
        end
        OWN_B: begin
          grant_valid = b_req;
          grant_who   = REQ_B;
        end
        default: begin
          if (a_req && b_req) begin
            grant_valid = 1'b1;
            grant_who   = rr_winner(last_grant);
          end else if (a_req) begin
            grant_valid = 1'b1;
            grant_who   = REQ_A;
          end else if (b_req) begin
            grant_valid = 1'b1;
            grant_who   = REQ_B;
          end
        end
      endcase
    end
  end

  // Ownership: an owner keeps the RAM exactly as long as it holds lock,
  // whether or not it is accessing this cycle. From OWN_NONE only a locked
  // grant takes ownership.
  always_comb begin
    state_next = OWN_NONE;
    case (state)
      OWN_A:   state_next = a_lock ? OWN_A : OWN_NONE;
      OWN_B:   state_next = b_lock ? OWN_B : OWN_NONE;
      default: begin
        if (grant_valid && (grant_who == REQ_A) && a_lock) begin
          state_next = OWN_A;
        end else if (grant_valid && (grant_who == REQ_B) && b_lock) begin
          state_next = OWN_B;
        end
      end
    endcase
  end

  // RAM request mux; address and data are don't-care without a grant.
  assign grant_we      = (grant_who == REQ_B) ? b_write_en : a_write_en;
  assign ram_addr      = (grant_who == REQ_B) ? b_addr     : a_addr;
  assign ram_din       = (grant_who == REQ_B) ? b_din      : a_din;
  assign ram_write_en  = grant_valid ? grant_we : '0;
  assign grant_is_read = grant_valid && (grant_we == '0);

  assign a_ack = grant_valid && (grant_who == REQ_A);
  assign b_ack = grant_valid && (grant_who == REQ_B);

  // Read return: the tag set in the grant cycle routes ram_dout back one
  // cycle later. Reset in that cycle discards the pending return.
  assign a_rd_valid = tag_valid && (tag_who == REQ_A) && !sync_reset;
  assign b_rd_valid = tag_valid && (tag_who == REQ_B) && !sync_reset;

  assign a_dout = sync_reset ? '0 : (a_rd_valid ? ram_dout : a_hold);
  assign b_dout = sync_reset ? '0 : (b_rd_valid ? ram_dout : b_hold);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the dout hold registers are reset because their value is visible
  // on a_dout/b_dout right after reset; they are two words, not a memory.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state      <= OWN_NONE;
      last_grant <= REQ_B;
      tag_valid  <= 1'b0;
      tag_who    <= REQ_A;
      a_hold     <= '0;
      b_hold     <= '0;
    end else begin
      state     <= state_next;
      tag_valid <= grant_is_read;
      if (grant_valid) begin
        last_grant <= grant_who;
      end
      if (grant_is_read) begin
        tag_who <= grant_who;
      end
      if (a_rd_valid) begin
        a_hold <= ram_dout;
      end
      if (b_rd_valid) begin
        b_hold <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_access_arbiter
//   Self-checking bench: two requester agents drive transactions (directed
//   queues, then random), a reference model predicts grants and RAM contents,
//   expected read returns go to a scoreboard queue, and a monitor pops and
//   compares them whenever a rd_valid is presented. An external RAM model
//   with 1-cycle read latency is attached to the ram_* port.
// ---------------------------------------------------------------------------
module tb_ram_access_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [BW-1:0] we;
    logic          lock;
  } txn_t;

  typedef struct {
    int          who;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  typedef struct {
    int cyc;
    int who;
  } gnt_t;

  logic clk = 1'b0;
  logic sync_reset;
  logic          a_req, a_lock, b_req, b_lock;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_din, b_din, ram_din, ram_dout, a_dout, b_dout;
  logic [BW-1:0] a_write_en, b_write_en, ram_write_en;
  logic          a_ack, b_ack, a_rd_valid, b_rd_valid;

  ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .a_req(a_req), .a_lock(a_lock), .a_addr(a_addr), .a_din(a_din),
    .a_write_en(a_write_en), .a_ack(a_ack), .a_rd_valid(a_rd_valid), .a_dout(a_dout),
    .b_req(b_req), .b_lock(b_lock), .b_addr(b_addr), .b_din(b_din),
    .b_write_en(b_write_en), .b_ack(b_ack), .b_rd_valid(b_rd_valid), .b_dout(b_dout),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write_en(ram_write_en),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h1234_5678 ^ (DW'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [BW-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input int addr, input logic [DW-1:0] din,
                              input logic [BW-1:0] we, input logic lock);
    txn_t t;
    t.addr = AW'(addr);
    t.din  = din;
    t.we   = we;
    t.lock = lock;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr = AW'($urandom_range(0, 31));
    t.din  = $urandom;
    t.we   = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom);
    t.lock = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // External RAM: byte-enabled write, registered read (1-cycle latency).
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int i = 0; i < BW; i++)
      if (ram_write_en[i]) ram_mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
    ram_dout <= ram_mem[ram_addr];
  end

  // Requester agents: hold a transaction until acked, then take the next.
  txn_t qa[$];
  txn_t qb[$];
  txn_t cur [2];
  bit   busy [2];
  bit   acked [2];
  bit   idle_lock [2];
  bit   rand_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    cycle++;
    for (int i = 0; i < 2; i++) begin
      if (acked[i]) busy[i] = 1'b0;
      if (!busy[i]) begin
        if (i == 0 && qa.size() > 0) begin
          cur[0] = qa.pop_front(); busy[0] = 1'b1;
        end else if (i == 1 && qb.size() > 0) begin
          cur[1] = qb.pop_front(); busy[1] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          cur[i] = rand_txn(); busy[i] = 1'b1;
        end
      end
      idle_lock[i] = rand_mode && ($urandom_range(0, 3) == 0);
    end
    a_req = busy[0]; a_addr = cur[0].addr; a_din = cur[0].din; a_write_en = cur[0].we;
    a_lock = busy[0] ? cur[0].lock : idle_lock[0];
    b_req = busy[1]; b_addr = cur[1].addr; b_din = cur[1].din; b_write_en = cur[1].we;
    b_lock = busy[1] ? cur[1].lock : idle_lock[1];
  end

  // Scoreboard of expected read returns and a log of observed grants.
  exp_t sb[$];
  gnt_t glog[$];
  int   a_rv_cnt = 0;
  int   b_rv_cnt = 0;
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;

  // Monitor: compares read returns and held dout values.
  always @(negedge clk) begin
    logic [1:0] exp_v;
    exp_t e;
    acked[0] = a_ack;
    acked[1] = b_ack;
    if (a_ack) glog.push_back('{cycle, 0});
    if (b_ack) glog.push_back('{cycle, 1});
    if (a_rd_valid) a_rv_cnt++;
    if (b_rd_valid) b_rv_cnt++;
    if (sync_reset) begin
      check("reset_rd_valid", {62'd0, a_rd_valid, b_rd_valid}, 64'd0);
      check("reset_a_dout", a_dout, 0);
      check("reset_b_dout", b_dout, 0);
      while (sb.size() > 0 && sb[0].due <= cycle) sb.delete(0);
      hold_a = '0;
      hold_b = '0;
    end else begin
      exp_v = 2'b00;
      if (sb.size() > 0 && sb[0].due == cycle) exp_v = (sb[0].who == 0) ? 2'b10 : 2'b01;
      check("rd_valid", {62'd0, a_rd_valid, b_rd_valid}, {62'd0, exp_v});
      if (exp_v != 2'b00) begin
        e = sb.pop_front();
        if (e.who == 0) begin check("a_rd_data", a_dout, e.data); hold_a = e.data; end
        else            begin check("b_rd_data", b_dout, e.data); hold_b = e.data; end
      end
      if (exp_v != 2'b10) check("a_dout_hold", a_dout, hold_a);
      if (exp_v != 2'b01) check("b_dout_hold", b_dout, hold_b);
    end
  end

  // Reference model: owner (-1 none, 0 a, 1 b), last granted requester and
  // memory contents, evaluated from the arbitration rules each cycle.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int m_owner = -1;
  int m_last  = 1;
  int g;
  logic [BW-1:0] g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_din;

  always @(negedge clk) begin
    #2;
    g = -1;
    if (sync_reset) begin
      m_owner = -1;
      m_last  = 1;
    end else begin
      if (m_owner == -1) begin
        if (a_req && b_req) g = (m_last == 0) ? 1 : 0;
        else if (a_req)     g = 0;
        else if (b_req)     g = 1;
        if      (g == 0 && a_lock) m_owner = 0;
        else if (g == 1 && b_lock) m_owner = 1;
      end else if (m_owner == 0) begin
        if (a_req) g = 0;
        if (!a_lock) m_owner = -1;
      end else begin
        if (b_req) g = 1;
        if (!b_lock) m_owner = -1;
      end
      if (g >= 0) m_last = g;
    end
    check("a_ack", {63'd0, a_ack}, {63'd0, g == 0});
    check("b_ack", {63'd0, b_ack}, {63'd0, g == 1});
    g_we   = (g == 0) ? a_write_en : (g == 1) ? b_write_en : '0;
    g_addr = (g == 1) ? b_addr : a_addr;
    g_din  = (g == 1) ? b_din  : a_din;
    check("ram_write_en", ram_write_en, g_we);
    if (g >= 0) begin
      check("ram_addr", ram_addr, g_addr);
      check("ram_din", ram_din, g_din);
      if (g_we == '0) sb.push_back('{g, ref_mem[g_addr], cycle + 1});
      else            ref_mem[g_addr] = merge(ref_mem[g_addr], g_din, g_we);
    end
  end

  task automatic wait_idle();
    int n;
    int pending;
    n = 0;
    pending = 1;
    while (pending != 0 && n < 400) begin
      @(negedge clk); #5;
      n++;
      pending = qa.size() + qb.size() + int'(busy[0]) + int'(busy[1]) + sb.size();
    end
    check("drain_pending", pending, 0);
  endtask

  task automatic check_log(input string name, input int exp_who []);
    check({name, "_count"}, glog.size(), exp_who.size());
    for (int i = 0; i < exp_who.size() && i < glog.size(); i++)
      check({name, "_who"}, glog[i].who, exp_who[i]);
  endtask

  initial begin
    int rel_cyc;
    int rv0;
    logic [DW-1:0] w;

    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    for (int i = 0; i < 2; i++) begin
      cur[i] = mk(0, '0, '0, 1'b0);
      busy[i] = 1'b0;
      acked[i] = 1'b0;
    end
    a_req = 0; a_lock = 0; a_addr = '0; a_din = '0; a_write_en = '0;
    b_req = 0; b_lock = 0; b_addr = '0; b_din = '0; b_write_en = '0;
    sync_reset = 1'b1;

    // Requests held through reset: a must win in the first cycle after it.
    qa.push_back(mk(1, '0, '0, 1'b0));
    qb.push_back(mk(2, '0, '0, 1'b0));
    repeat (3) @(posedge clk);
    #1 sync_reset = 1'b0;
    @(negedge clk);
    rel_cyc = cycle;
    wait_idle();
    check_log("post_reset", '{0, 1});
    if (glog.size() > 0) check("post_reset_first_cycle", glog[0].cyc, rel_cyc);

    // Continuous reads from both, lock=0: strict alternation, back to back.
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(mk(16'h40 + i, '0, '0, 1'b0));
      qb.push_back(mk(16'h48 + i, '0, '0, 1'b0));
    end
    wait_idle();
    check_log("alternate", '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1});
    for (int i = 1; i < glog.size(); i++) check("alternate_gap", glog[i].cyc - glog[i-1].cyc, 1);

    // a locked for 4 accesses, then releases; b gets the next cycle.
    glog.delete();
    for (int i = 0; i < 4; i++) qa.push_back(mk(16'h60 + i, '0, '0, 1'b1));
    qa.push_back(mk(16'h64, '0, '0, 1'b0));
    qa.push_back(mk(16'h65, '0, '0, 1'b0));
    qb.push_back(mk(16'h66, '0, '0, 1'b0));
    wait_idle();
    check_log("lock", '{0, 0, 0, 0, 0, 1, 0});

    // Read-modify-write of 0x10 with a partial (low half) write.
    qa.push_back(mk(16'h10, '0, '0, 1'b1));
    qa.push_back(mk(16'h10, 32'hDEAD_BEEF, 4'b0011, 1'b0));
    qa.push_back(mk(16'h10, '0, '0, 1'b0));
    wait_idle();
    w = init_word(16'h10);
    check("rmw_result", a_dout, {w[31:16], 16'hBEEF});

    // b writes, a reads the same address straight after.
    glog.delete();
    rv0 = b_rv_cnt;
    qb.push_back(mk(16'h20, 32'hCAFE_F00D, 4'b1111, 1'b0));
    qa.push_back(mk(16'h20, '0, '0, 1'b0));
    wait_idle();
    check_log("wr_rd", '{1, 0});
    check("wr_rd_a_dout", a_dout, 32'hCAFE_F00D);
    check("wr_rd_no_b_rd_valid", b_rv_cnt, rv0);

    // Reset the cycle after a locked read grant: no return, a wins next.
    qa.push_back(mk(16'h30, '0, '0, 1'b1));
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (a_ack) break;
    end
    check("rst_read_granted", {63'd0, a_ack}, 64'd1);
    rv0 = a_rv_cnt + b_rv_cnt;
    @(posedge clk); #1 sync_reset = 1'b1;
    @(posedge clk); #1 sync_reset = 1'b0;
    @(negedge clk);
    check("rst_no_rd_valid", a_rv_cnt + b_rv_cnt, rv0);
    glog.delete();
    qa.push_back(mk(16'h31, '0, '0, 1'b0));
    qb.push_back(mk(16'h32, '0, '0, 1'b0));
    wait_idle();
    check_log("rst_contention", '{0, 1});

    // Random traffic against the reference model.
    rand_mode = 1'b1;
    repeat (10000) @(posedge clk);
    rand_mode = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14: word-address width of the shared RAM.
REQ-002 Parameter DATA_WIDTH, default 32: data width, multiple of 8; byte-enable width is DATA_WIDTH/8.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 sync_reset  in  1  reset, synchronous, active-high.
REQ-005 Per requester x in {a, b}: x_req in 1 (access request); x_lock in 1 (keep ownership after this access); x_addr in ADDR_WIDTH; x_din in DATA_WIDTH; x_write_en in DATA_WIDTH/8 (zero means read).
REQ-006 Per requester x: x_ack out 1 (access issued to RAM this cycle); x_rd_valid out 1; x_dout out DATA_WIDTH.
REQ-007 ram_addr out ADDR_WIDTH; ram_din out DATA_WIDTH; ram_write_en out DATA_WIDTH/8; ram_dout in DATA_WIDTH (RAM read latency is exactly 1 cycle).

Function
REQ-008 At most one access SHALL be issued per cycle; ram_* SHALL carry the granted requester's addr/din/write_en combinationally in the grant cycle, and x_ack SHALL be asserted in that same cycle.
REQ-009 With no grant, ram_write_en SHALL be 0; ram_addr and ram_din are don't-care.
REQ-010 Requesters SHALL hold req/addr/din/write_en stable until ack; the arbiter never acks a deasserted req.
REQ-011 The owner state machine has states OWN_NONE, OWN_A, OWN_B.
REQ-012 In OWN_NONE: a single requester is granted; if both request, the requester not granted most recently wins (round-robin pointer last_grant, reset value b so a wins first).
REQ-013 A grant with x_lock=1 SHALL move to OWN_x; a grant with x_lock=0 SHALL return to or stay in OWN_NONE.
REQ-014 In OWN_x: only x may be granted; the other requester waits regardless of its req. The state SHALL stay OWN_x while x_lock=1, including cycles where x_req=0.
REQ-015 In OWN_x: x_lock=0 in any cycle (granted or not) SHALL move to OWN_NONE next cycle; last_grant SHALL update only on a grant.
REQ-016 A read grant SHALL set a 1-cycle return tag; on the next cycle x_rd_valid=1 for the tagged requester only, with x_dout=ram_dout.
REQ-017 A write grant SHALL produce no rd_valid.
REQ-018 x_dout SHALL hold its last returned value when x_rd_valid=0.
REQ-019 Back-to-back grants SHALL be supported: a grant and a rd_valid for the previous read may occur in the same cycle, to the same or different requesters.
REQ-020 Partial byte writes SHALL pass write_en bits through unmodified.

Reset
REQ-021 While sync_reset=1: state=OWN_NONE, last_grant=b, return tag cleared, a_ack=b_ack=0, a_rd_valid=b_rd_valid=0, ram_write_en=0, a_dout=b_dout=0.
REQ-022 A sync_reset asserted in the cycle after a read grant SHALL suppress that read's rd_valid.
REQ-023 A request held through reset SHALL be granted in the first cycle after reset deasserts, per REQ-012.

Structure
REQ-024 The owner-state encoding (OWN_NONE/OWN_A/OWN_B) and the requester-index constants SHALL live in the shared memory-subsystem package.
REQ-025 The arbiter SHALL be a single module with no sub-modules; the RAM is instantiated by the parent, with ram_* connected to single_port_ram.

Verification
REQ-026 Both requesters reading continuously with lock=0: grants alternate a,b,a,b...; each rd_valid arrives exactly 1 cycle after its ack on the correct port.
REQ-027 a holds lock=1 for 4 accesses while b requests: b_ack=0 for those 4 cycles. After a drops lock, b_ack=1 on the next cycle even if a_req=1.
REQ-028 Read-modify-write: a reads addr 0x10 (lock=1), then writes 0xDEADBEEF with write_en=4'b0011 (lock=0). A later read of 0x10 returns the old upper half and 0xBEEF in the low half.
REQ-029 Write by b followed directly by a read by a on the same address: a_dout equals the written data, and b_rd_valid never pulses.
REQ-030 sync_reset pulsed the cycle after a read grant: no rd_valid, state OWN_NONE, and the next contention is granted to a.
REQ-031 Random req/lock/write_en run of 10k cycles against a reference memory model: no double grant, no lost or duplicated rd_valid, and all data matches.
